ysyx_22050039_ifu: RTL and testbench

YSYX_22050039_IFU -- requirements
Module: ysyx_22050039_IFU

---
 rtl/ysyx_22050039_ifu.sv | 106 ++++++++++
 tb/tb_ysyx_22050039_ifu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_ifu.sv
// rtl/ysyx_22050039_ifu.sv - instruction fetch unit: one outstanding fetch, decoder handshake, halt on ebreak/misalign
module ysyx_22050039_ifu #(
  parameter int XLEN = 64,
  parameter int INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  input  logic                pc_wen,
  input  logic [XLEN-1:0]     pc_wdata,
  input  logic                ebreak,
  output logic                halted,
  output logic                misalign,
  output logic [XLEN-1:0]     retired
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [XLEN-1:0]     pc_nx;
  logic [INST_LEN-1:0] inst_nx;
  logic [XLEN-1:0]     retired_nx;
  logic                misalign_nx;

  // Handshake outputs are gated by rst so nothing is offered while reset is held.
  assign imem_req_valid = rst & (state == S_REQ);
  assign inst_valid     = rst & (state == S_HOLD);
  assign imem_addr      = pc;
  assign halted         = (state == S_HALT);

  // State register and architectural registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst     <= '0;
      retired  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      inst     <= inst_nx;
      retired  <= retired_nx;
      misalign <= misalign_nx;
    end
  end

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    inst_nx     = inst;
    retired_nx  = retired;
    misalign_nx = misalign;
    case (state)
      S_REQ: begin
        if (imem_req_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Only the response to our own request is captured here.
        if (imem_rsp_valid) begin
          inst_nx  = imem_rsp_data;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          retired_nx = retired + XLEN'(1);
          if (ebreak) begin
            state_nx = S_HALT;
          end else if (pc_wen && pc_wdata[1]) begin
            // Target not 4-byte aligned: stop with pc left on the offending instruction.
            state_nx    = S_HALT;
            misalign_nx = 1'b1;
          end else if (pc_wen) begin
            pc_nx    = pc_wdata & ~XLEN'(1);
            state_nx = S_REQ;
          end else begin
            pc_nx    = pc + XLEN'(4);
            state_nx = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: state_nx = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// tb/tb_ysyx_22050039_ifu.sv - self-checking bench for the fetch unit with a transaction-level model
module tb_ysyx_22050039_ifu;

  localparam int XLEN = 64;
  localparam int INST_LEN = 32;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_addr;
  logic                imem_rsp_valid;
  logic [INST_LEN-1:0] imem_rsp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     pc;
  logic                pc_wen;
  logic [XLEN-1:0]     pc_wdata;
  logic                ebreak;
  logic                halted;
  logic                misalign;
  logic [XLEN-1:0]     retired;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 0;

  // memory model controls
  int  mem_lat = 1;
  bit  mem_fixed = 1;
  bit  stray = 0;
  logic mem_v = 0;
  logic [31:0] mem_d = '0;

  // behavioural model state
  logic [63:0] m_pc, m_ret;
  bit m_halt, m_mis, m_out, m_have;
  logic [31:0] m_inst;
  int hs_cnt = 0;
  logic [63:0] acc_addr[$];
  int acc_cyc[$];
  int hs_cyc[$];

  always #5 clk = ~clk;

  assign imem_rsp_valid = mem_v | stray;
  assign imem_rsp_data  = stray ? 32'hdead_beef : mem_d;

  ysyx_22050039_ifu #(.XLEN(XLEN), .INST_LEN(INST_LEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata), .ebreak(ebreak),
    .halted(halted), .misalign(misalign), .retired(retired)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return mem_fixed ? 32'h0000_0013 : (a[31:0] ^ 32'h00c0_ffe3);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Memory: accepts a request, answers mem_lat cycles later with a word derived from the address.
  initial begin
    bit r, a, f;
    logic [63:0] ad, maddr;
    bit pend;
    int cnt;
    pend = 0; cnt = 0; maddr = '0;
    forever begin
      @(negedge clk); #3;
      r = rst; a = imem_req_valid && imem_req_ready; f = mem_v; ad = imem_addr;
      @(posedge clk); #1;
      if (!r) begin
        pend = 0; mem_v = 0;
      end else begin
        if (f) pend = 0;
        else if (pend) cnt--;
        if (a) begin pend = 1; cnt = mem_lat; maddr = ad; end
        mem_v = pend && (cnt == 1);
        mem_d = mem_word(maddr);
      end
    end
  end

  // Model: compare outputs mid-cycle, then advance model by the transaction the coming edge completes.
  initial begin
    bit reqx;
    forever begin
      @(negedge clk); #2;
      cyc++;
      reqx = !m_halt && !m_out && !m_have;
      if (chk_en) begin
        if (!rst) begin
          chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
          chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        end else begin
          chk("req_valid", 64'(imem_req_valid), 64'(reqx));
          if (reqx) chk("imem_addr", imem_addr, m_pc);
          chk("inst_valid", 64'(inst_valid), 64'(m_have));
          if (m_have) chk("inst", 64'(inst), 64'(m_inst));
          chk("pc", pc, m_pc);
          chk("retired", retired, m_ret);
          chk("halted", 64'(halted), 64'(m_halt));
          chk("misalign", 64'(misalign), 64'(m_mis));
        end
      end
      if (!rst) begin
        m_pc = RST_PC; m_ret = 0; m_halt = 0; m_mis = 0; m_out = 0; m_have = 0;
      end else if (reqx && imem_req_ready) begin
        m_out = 1; acc_addr.push_back(m_pc); acc_cyc.push_back(cyc);
      end else if (m_out && imem_rsp_valid) begin
        m_out = 0; m_have = 1; m_inst = imem_rsp_data;
      end else if (m_have && inst_ready) begin
        m_have = 0; m_ret = m_ret + 1; hs_cnt++; hs_cyc.push_back(cyc);
        if (ebreak) m_halt = 1;
        else if (pc_wen && pc_wdata[1]) begin m_halt = 1; m_mis = 1; end
        else if (pc_wen) m_pc = {pc_wdata[63:1], 1'b0};
        else m_pc = m_pc + 64'd4;
      end
    end
  end

  task automatic wait_hs(input int n);
    for (int i = 0; i < 100 && hs_cnt < n; i++) @(negedge clk);
    if (hs_cnt < n) begin errors++; checks++; $display("FAIL wait_hs: got %0d expected %0d", hs_cnt, n); end
  endtask

  task automatic wait_iv();
    int i;
    for (i = 0; i < 50 && !inst_valid; i++) begin @(negedge clk); #1; end
    if (!inst_valid) begin errors++; checks++; $display("FAIL wait_iv: got 0 expected 1"); end
  endtask

  task automatic wait_req();
    int i;
    for (i = 0; i < 50 && !imem_req_valid; i++) begin @(negedge clk); #1; end
    if (!imem_req_valid) begin errors++; checks++; $display("FAIL wait_req: got 0 expected 1"); end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0; imem_req_ready = 0; inst_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] si;
    logic [63:0] sp;
    int ba, bh;
    rst = 0; imem_req_ready = 0; inst_ready = 0; pc_wen = 0; pc_wdata = '0; ebreak = 0;
    repeat (2) @(negedge clk);
    chk_en = 1; #1;
    chk("reset_pc", pc, 64'h8000_0000);
    chk("reset_retired", retired, 64'd0);
    chk("reset_inst", 64'(inst), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_misalign", 64'(misalign), 64'd0);
    chk("reset_req_valid", 64'(imem_req_valid), 64'd0);

    // release with memory not ready: request must be up in the first cycle after release
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_addr, 64'h8000_0000);

    // back-to-back fetch, everything ready
    ba = acc_addr.size(); bh = hs_cyc.size();
    imem_req_ready = 1; inst_ready = 1; mem_fixed = 1; mem_lat = 1;
    wait_iv();
    chk("first_inst", 64'(inst), 64'h13);
    wait_hs(bh + 3); #1;
    if (acc_addr.size() >= ba + 3 && hs_cyc.size() >= bh + 3) begin
      chk("addr0", acc_addr[ba], 64'h8000_0000);
      chk("addr1", acc_addr[ba+1], 64'h8000_0004);
      chk("addr2", acc_addr[ba+2], 64'h8000_0008);
      chk("latency", 64'(hs_cyc[bh] - acc_cyc[ba]), 64'd2);
      chk("throughput1", 64'(hs_cyc[bh+1] - hs_cyc[bh]), 64'd3);
      chk("throughput2", 64'(hs_cyc[bh+2] - hs_cyc[bh+1]), 64'd3);
    end
    chk("retired3", retired, 64'd3);

    // decoder stall in HOLD for 5 cycles, with a stray response thrown in
    inst_ready = 0; mem_fixed = 0; mem_lat = 2;
    wait_iv();
    si = inst; sp = pc;
    chk("stall_pc", sp, 64'h8000_000c);
    for (int i = 0; i < 5; i++) begin
      stray = (i == 1 || i == 2);
      chk("stall_iv", 64'(inst_valid), 64'd1);
      chk("stall_inst", 64'(inst), 64'(si));
      chk("stall_pc_hold", pc, sp);
      chk("stall_req", 64'(imem_req_valid), 64'd0);
      @(negedge clk); #1;
    end
    stray = 0; inst_ready = 1;
    chk("stall_inst_end", 64'(inst), 64'(si));
    @(negedge clk); #1;
    wait_req();
    chk("after_stall_addr", imem_addr, 64'h8000_0010);

    // redirect to odd target: bit 0 dropped
    inst_ready = 0;
    wait_iv();
    pc_wen = 1; pc_wdata = 64'h8000_0101; inst_ready = 1;
    @(negedge clk); pc_wen = 0; pc_wdata = 64'h1234_5678_9abc_def2; #1;
    wait_req();
    chk("redirect_addr", imem_addr, 64'h8000_0100);

    // ebreak beats a misaligned redirect
    inst_ready = 0;
    wait_iv();
    ebreak = 1; pc_wen = 1; pc_wdata = 64'h8000_0102; inst_ready = 1;
    @(negedge clk); ebreak = 0; pc_wen = 0; #1;
    chk("ebreak_halted", 64'(halted), 64'd1);
    chk("ebreak_misalign", 64'(misalign), 64'd0);
    chk("ebreak_retired", retired, 64'd6);
    chk("ebreak_pc", pc, 64'h8000_0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("halt_no_req", 64'(imem_req_valid), 64'd0);
    end

    // misaligned redirect halts with misalign set
    do_reset();
    chk("post_reset_halted", 64'(halted), 64'd0);
    imem_req_ready = 1;
    wait_iv();
    pc_wen = 1; pc_wdata = 64'h8000_0102; inst_ready = 1;
    @(negedge clk); pc_wen = 0; #1;
    chk("mis_halted", 64'(halted), 64'd1);
    chk("mis_flag", 64'(misalign), 64'd1);
    chk("mis_pc", pc, 64'h8000_0000);
    chk("mis_retired", retired, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("mis_no_req", 64'(imem_req_valid), 64'd0);
    end

    // reset while a fetch is outstanding; late responses must be ignored
    do_reset();
    imem_req_ready = 1; inst_ready = 1; mem_lat = 3;
    wait_req();
    @(negedge clk); #1;
    chk("wait_no_req", 64'(imem_req_valid), 64'd0);
    rst = 0;
    @(negedge clk); stray = 1;
    @(negedge clk); rst = 1; imem_req_ready = 0; #1;
    chk("rwait_addr", imem_addr, 64'h8000_0000);
    chk("rwait_retired", retired, 64'd0);
    chk("rwait_iv", 64'(inst_valid), 64'd0);
    chk("rwait_req", 64'(imem_req_valid), 64'd1);
    @(negedge clk); stray = 0; imem_req_ready = 1; #1;
    chk("rwait_iv2", 64'(inst_valid), 64'd0);
    wait_iv();
    chk("rwait_inst", 64'(inst), 64'h80c0_ffe3);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
